gene_radix_sort: RTL and testbench

GENE_RADIX_SORT -- requirements
Module: gene_radix_sort

---
 rtl/gene_radix_sort_pkg.sv | 31 +++
 rtl/gene_radix_sort_if.sv | 21 ++
 rtl/gene_radix_sort_counter.sv | 18 +
 rtl/gene_radix_sort.sv | 131 +++++++++++++
 tb/tb_gene_radix_sort.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/gene_radix_sort_pkg.sv
// Shared state/command codes and sizing for the gene sorter, gene file and controller.
// SORT_SKIP_UNIFORM_EN adds the SCAN state used to skip bits that are identical across all genes.
package gene_sort_pkg;
  localparam int POPULATION_DEF          = 24;
  localparam int PRIMARY_INPUT_COUNT_DEF = 8;

  function automatic int fit_w(input int primary_input_count);
    return primary_input_count + 2;
  endfunction

  typedef enum logic [3:0] {
    S_IDLE   = 4'b0000,
`ifdef SORT_SKIP_UNIFORM_EN
    S_SCAN   = 4'b0010,
`endif
    S_ONES   = 4'b0011,
    S_ZEROS  = 4'b0100,
    S_COMMIT = 4'b0101,
    S_DONE   = 4'b1001
  } sort_state_t;

  // Commands decoded by the gene register file
  localparam logic [3:0] CMD_IDLE       = 4'b0000;
  localparam logic [3:0] CMD_SCAN       = 4'b0010;
  localparam logic [3:0] CMD_ONES_SKIP  = 4'b0011;
  localparam logic [3:0] CMD_ONES_WR    = 4'b0111;
  localparam logic [3:0] CMD_ZEROS_SKIP = 4'b0100;
  localparam logic [3:0] CMD_ZEROS_WR   = 4'b0110;
  localparam logic [3:0] CMD_COMMIT     = 4'b0101;
  localparam logic [3:0] CMD_DONE       = 4'b1001;
endpackage

// File: rtl/gene_radix_sort_if.sv
// Sorter <-> gene register file / controller bundle.
interface gene_radix_sort_if import gene_sort_pkg::*; #(
  parameter int FIT_W = fit_w(PRIMARY_INPUT_COUNT_DEF)
);
  logic             start;
  logic [FIT_W-1:0] sortGene;
  logic [7:0]       sortGeneCount;
  logic [7:0]       sortedCounter;
  logic [3:0]       state_sortFSM;
  logic [3:0]       baseBit;
  logic             sortDone;

  modport master (
    output start, sortGene,
    input  sortGeneCount, sortedCounter, state_sortFSM, baseBit, sortDone
  );
  modport slave (
    input  start, sortGene,
    output sortGeneCount, sortedCounter, state_sortFSM, baseBit, sortDone
  );
endinterface

// File: rtl/gene_radix_sort_counter.sv
// Pass index counter: steps 0..last_idx, wraps to 0, flags the final index.
module sort_pass_counter (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] last_idx,
  output logic [7:0] count,
  output logic       last
);
  assign last = (count == last_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= last ? 8'd0 : count + 8'd1;
  end
endmodule

// File: rtl/gene_radix_sort.sv
// LSD binary radix sorter driving the gene register file; descending, stable.
// SORT_SKIP_UNIFORM_EN: precede each bit with a SCAN pass and skip bits uniform across all genes.
module gene_radix_sort import gene_sort_pkg::*; #(
  parameter int population        = POPULATION_DEF,
  parameter int primaryInputCount = PRIMARY_INPUT_COUNT_DEF
)(
  input logic             CLOCK_50,
  input logic             reset,
  gene_radix_sort_if.slave bus
);
  localparam int         FIT_W    = fit_w(primaryInputCount);
  localparam logic [7:0] POP      = 8'(population);
  localparam logic [7:0] LAST_IDX = 8'(population - 1);
  localparam logic [3:0] TOP_BIT  = 4'(FIT_W - 1);
`ifdef SORT_SKIP_UNIFORM_EN
  localparam sort_state_t FIRST = S_SCAN;
`else
  localparam sort_state_t FIRST = S_ONES;
`endif

  sort_state_t state;
  logic [7:0]  sorted_cnt;
  logic [3:0]  base_bit;
  logic        done_q;
  logic [7:0]  gene_idx;
  logic        cnt_last, cnt_en, bit_val;
  logic [3:0]  cmd;

  assign bit_val = bus.sortGene[base_bit];
  assign cnt_en  = (state == S_ONES) || (state == S_ZEROS)
`ifdef SORT_SKIP_UNIFORM_EN
                || (state == S_SCAN)
`endif
                ;

  sort_pass_counter u_gene_cnt (
    .clk      (CLOCK_50),
    .rst      (reset),
    .clr      (state == S_IDLE),
    .en       (cnt_en),
    .last_idx (LAST_IDX),
    .count    (gene_idx),
    .last     (cnt_last)
  );

`ifdef SORT_SKIP_UNIFORM_EN
  logic [7:0] ones_cnt, ones_total;
  assign ones_total = ones_cnt + {7'd0, bit_val};
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      sorted_cnt <= '0;
      base_bit   <= '0;
      done_q     <= 1'b0;
`ifdef SORT_SKIP_UNIFORM_EN
      ones_cnt   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: if (bus.start) begin
          base_bit   <= '0;
          sorted_cnt <= '0;
`ifdef SORT_SKIP_UNIFORM_EN
          ones_cnt   <= '0;
`endif
          state      <= FIRST;
        end
`ifdef SORT_SKIP_UNIFORM_EN
        S_SCAN: begin
          ones_cnt <= cnt_last ? 8'd0 : ones_total;
          if (cnt_last) begin
            // A bit equal in every gene leaves the order untouched
            if (ones_total != 8'd0 && ones_total != POP) state <= S_ONES;
            else if (base_bit == TOP_BIT) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else base_bit <= base_bit + 4'd1;
          end
        end
`endif
        S_ONES: begin
          if (bit_val) sorted_cnt <= sorted_cnt + 8'd1;
          if (cnt_last) state <= S_ZEROS;
        end
        S_ZEROS: begin
          if (!bit_val) sorted_cnt <= sorted_cnt + 8'd1;
          if (cnt_last) state <= S_COMMIT;
        end
        S_COMMIT: begin
          sorted_cnt <= '0;
          if (base_bit == TOP_BIT) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            base_bit <= base_bit + 4'd1;
            state    <= FIRST;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Mealy command: write decision follows the live fitness bit
  always_comb begin
    cmd = CMD_IDLE;
    case (state)
`ifdef SORT_SKIP_UNIFORM_EN
      S_SCAN:   cmd = CMD_SCAN;
`endif
      S_ONES:   cmd = bit_val  ? CMD_ONES_WR  : CMD_ONES_SKIP;
      S_ZEROS:  cmd = !bit_val ? CMD_ZEROS_WR : CMD_ZEROS_SKIP;
      S_COMMIT: cmd = CMD_COMMIT;
      S_DONE:   cmd = CMD_DONE;
      default:  cmd = CMD_IDLE;
    endcase
  end

  assign bus.sortGeneCount = gene_idx;
  assign bus.sortedCounter = sorted_cnt;
  assign bus.baseBit       = base_bit;
  assign bus.sortDone      = done_q;
  assign bus.state_sortFSM = cmd;

  commit_full_a: assert property (@(posedge CLOCK_50) disable iff (reset)
    state == S_COMMIT |-> sorted_cnt == POP);
endmodule

// File: tb/tb_gene_radix_sort.sv
// Randomized scoreboard bench: behavioural gene file plus a stable-sort reference model.
module tb_gene_radix_sort;
  import gene_sort_pkg::*;
  localparam int POP   = 24;
  localparam int PIC   = 8;
  localparam int FIT_W = PIC + 2;

  typedef logic [POP-1:0][7:0] arr_t;
  typedef struct { arr_t order; int lat; int t0; } exp_t;

  logic CLOCK_50 = 1'b0;
  logic reset    = 1'b1;
  logic load     = 1'b0;
  int   cyc      = 0;
  int   checks   = 0;
  int   errors   = 0;
  bit   chk_pass = 1'b0;
  exp_t e_mon;

  logic [FIT_W-1:0] fit      [POP];
  logic [7:0]       unsorted [POP];
  logic [7:0]       sorted   [POP];
  arr_t q_pass[$];
  exp_t q_done[$];

  gene_radix_sort_if #(.FIT_W(FIT_W)) bus();

  gene_radix_sort #(.population(POP), .primaryInputCount(PIC)) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus)
  );

  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // Behavioural gene register file: ids stored, fitness looked up per id
  assign bus.sortGene = (bus.sortGeneCount < POP) ? fit[unsorted[bus.sortGeneCount]] : '0;

  always @(posedge CLOCK_50) begin
    if (load) begin
      for (int i = 0; i < POP; i++) unsorted[i] <= 8'(i);
    end else begin
      case (bus.state_sortFSM)
        CMD_ONES_WR, CMD_ZEROS_WR:
          if (bus.sortedCounter < POP && bus.sortGeneCount < POP)
            sorted[bus.sortedCounter] <= unsorted[bus.sortGeneCount];
        CMD_COMMIT: for (int i = 0; i < POP; i++) unsorted[i] <= sorted[i];
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=event expected=none", name);
  endtask

  task automatic chk_arr(input string name, input arr_t exp);
    int bad = -1;
    for (int i = 0; i < POP; i++) if (bad < 0 && unsorted[i] != exp[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s idx=%0d actual_id=%0d expected_id=%0d", name, bad, unsorted[bad], exp[bad]);
    end
  endtask

  // Reference: stable descending sort of gene ids by fitness
  function automatic arr_t stable_desc();
    int ord[POP];
    int t;
    arr_t r;
    for (int i = 0; i < POP; i++) ord[i] = i;
    for (int i = 1; i < POP; i++)
      for (int j = i; j > 0 && fit[ord[j-1]] < fit[ord[j]]; j--) begin
        t = ord[j]; ord[j] = ord[j-1]; ord[j-1] = t;
      end
    for (int i = 0; i < POP; i++) r[i] = 8'(ord[i]);
    return r;
  endfunction

  task automatic build_exp(output exp_t e);
    arr_t cur, nxt;
    int   k, ones;
    for (int i = 0; i < POP; i++) cur[i] = 8'(i);
    e.lat = 0;
    for (int b = 0; b < FIT_W; b++) begin
      ones = 0;
      for (int i = 0; i < POP; i++) ones += int'(fit[cur[i]][b]);
`ifdef SORT_SKIP_UNIFORM_EN
      e.lat += POP;
      if (ones == 0 || ones == POP) continue;
`endif
      e.lat += 2 * POP + 1;
      k = 0;
      for (int i = 0; i < POP; i++) if (fit[cur[i]][b])  begin nxt[k] = cur[i]; k++; end
      for (int i = 0; i < POP; i++) if (!fit[cur[i]][b]) begin nxt[k] = cur[i]; k++; end
      cur = nxt;
      q_pass.push_back(cur);
    end
    e.order = stable_desc();
    e.t0    = 0;
  endtask

  // Monitor: pass snapshots after each COMMIT, final order and latency at sortDone
  always @(negedge CLOCK_50) begin
    if (reset) chk_pass = 1'b0;
    else begin
      if (chk_pass) begin
        chk_pass = 1'b0;
        if (q_pass.size() == 0) fail("pass_extra");
        else chk_arr("pass_order", q_pass.pop_front());
      end
      if (bus.state_sortFSM == CMD_COMMIT) begin
        check("commit_count", bus.sortedCounter, POP);
        chk_pass = 1'b1;
      end
      if (bus.sortDone) begin
        if (q_done.size() == 0) fail("done_extra");
        else begin
          e_mon = q_done.pop_front();
          check("latency", cyc - e_mon.t0, e_mon.lat);
          chk_arr("final_order", e_mon.order);
          check("done_cmd", bus.state_sortFSM, CMD_DONE);
        end
      end
    end
  end

  task automatic start_sort(input int hold);
    exp_t e;
    load = 1'b1;
    @(negedge CLOCK_50);
    load = 1'b0;
    build_exp(e);
    bus.start = 1'b1;
    @(negedge CLOCK_50);
    e.t0 = cyc;
    q_done.push_back(e);
    for (int i = 1; i < hold; i++) @(negedge CLOCK_50);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (q_done.size() != 0 && n < 3000) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (q_done.size() != 0) begin
      fail("timeout");
      q_done.delete();
    end
    check("pass_queue_empty", q_pass.size(), 0);
    q_pass.delete();
    repeat (5) @(negedge CLOCK_50);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_cmd"},    bus.state_sortFSM, 0);
    check({tag, "_gcount"}, bus.sortGeneCount, 0);
    check({tag, "_scount"}, bus.sortedCounter, 0);
    check({tag, "_base"},   bus.baseBit, 0);
    check({tag, "_done"},   bus.sortDone, 0);
  endtask

  task automatic rand_fit(input int max);
    for (int i = 0; i < POP; i++) fit[i] = FIT_W'($urandom_range(0, max));
  endtask

  initial begin
    bus.start = 1'b0;
    rand_fit(0);
    load = 1'b1;
    #1 check_zero("init");
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    load  = 1'b0;

    rand_fit(1023);
    fit[0] = 3; fit[1] = 1; fit[2] = 2; fit[3] = 0;
    start_sort(1); wait_done();

    for (int i = 0; i < POP; i++) fit[i] = 5;
    start_sort(1); wait_done();

    rand_fit(1023);
    fit[0] = 1023; fit[1] = 0; fit[2] = 512; fit[3] = 511;
    start_sort(1); wait_done();

    rand_fit(7);    start_sort(1); wait_done();
    rand_fit(1023); start_sort(1); wait_done();
    rand_fit(3);    start_sort(1); wait_done();

    rand_fit(1023); start_sort(10); wait_done();

    rand_fit(1023);
    start_sort(1);
    repeat (98) @(negedge CLOCK_50);
    #2 reset = 1'b1;
    #1 check_zero("midrst");
    q_done.delete();
    q_pass.delete();
    repeat (2) @(negedge CLOCK_50);
    #2 reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check("post_rst_cmd", bus.state_sortFSM, CMD_IDLE);
    check("post_rst_done", bus.sortDone, 0);
    start_sort(1); wait_done();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
